divu_sequencer: RTL

Multi-cycle controller for the unsigned divide resource (`divu`) and its LO/HI result registers. It accepts a decoded `divu` issue from the instruction decode stage and runs a WIDTH-iteration restoring division, one quotient bit per cycle. It owns LO/HI, serves `mflo`/`mfhi` reads, and stalls the pipeline when a read or a new divide arrives while a division is in flight. It sits beside the ALU in the execute stage, between the instruction typer's `divu`/`mflo` signals and the register-file writeback mux.

---
 rtl/divu_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/divu_sequencer.sv
// divu_sequencer: multi-cycle unsigned divide controller that owns LO/HI.
// It runs a restoring division that produces one quotient bit per cycle.
// It stalls the pipeline when mflo/mfhi or a new divu arrives mid-divide.
// Optional feature macro: DIVU_FAST_ZERO_EN. When it is defined, a divide
// by zero skips the iterations and completes in one cycle.
module divu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mflo_req,
  input  logic             mfhi_req,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  // The partial remainder is always below the divisor between iterations.
  // Its top bit is therefore always zero, and only WIDTH bits are stored.
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // One restoring-division step: shift {rem,quo} left, then try the subtract.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_d  = rem_sh[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sequencer FSM with registered busy/done and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            dvs_q <= divisor;
            quo_q <= dividend;
            rem_q <= '0;
            dz_q  <= (divisor == '0);
`ifdef DIVU_FAST_ZERO_EN
            if (divisor == '0) begin
              cnt_q   <= '0;
              lo_q    <= '1;
              hi_q    <= dividend;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= CW'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= S_BUSY;
            end
`else
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            lo_q    <= quo_d;
            hi_q    <= rem_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall    = busy_q & (start | mflo_req | mfhi_req);
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
